// File: rtl/boot_loaded_mem_pkg.sv
// Shared types and constants for the boot-loaded unified memory.
package boot_loaded_mem_pkg;

  // Block lifecycle: receive the image, hold the core for one cycle, then serve it.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // addi x0, x0, 0 -- harmless instruction fed to the fetch port outside RUN.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Lane-0 aligned access masks driven by the core.
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/boot_loaded_mem_lane_align.sv
// Byte-lane alignment between the core's lane-0 view and the word array.
// Purely combinational so it can be reused by other address decoders.
module lane_align (
  input  logic [1:0]  st_off,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rword,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0] mask_wide;

  // Shift mask/data up to the addressed lane; lanes pushed past lane 3 are dropped
  // but reported as a word-boundary crossing.
  always_comb begin
    mask_wide = 8'h00;
    mask_wide = {4'b0000, wmask} << st_off;
    st_mask   = mask_wide[3:0];
    misalign  = |mask_wide[7:4];
    st_data   = wdata << {st_off, 3'b000};
    ld_data   = rword >> {ld_off, 3'b000};
  end

endmodule

// File: rtl/boot_loaded_mem.sv
// Unified instruction/data memory that is filled over a valid/ready stream
// after reset and then serves the core's fetch and data ports.
//
// Load stream handshake: a beat transfers on a rising clk edge where
// ld_valid_i and ld_ready_o are both high; ld_ready_o is high only in LOAD and
// does not depend on ld_valid_i. ld_data_i/ld_last_i are only looked at on a
// transferring beat.
//
// The FSM state is held in state_q, which is the probe point for the state.
module boot_loaded_mem #(
  parameter  int          DEPTH = 512,
  parameter  logic [31:0] NOP   = boot_loaded_mem_pkg::NOP,
  localparam int          AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW+1:0] instr_addr_i,
  output logic [31:0]   instr_o,
  input  logic [AW+1:0] data_addr_i,
  input  logic [31:0]   data_i,
  input  logic          wen0_i,
  input  logic [3:0]    wmask0_i,
  output logic [31:0]   data_o,
  input  logic          ld_valid_i,
  input  logic [31:0]   ld_data_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          core_rst_n_o,
  output logic          misalign_o
);

  import boot_loaded_mem_pkg::*;

  state_e        state_q;
  logic [AW-1:0] wcnt_q;
  logic          misalign_q;
  logic          instr_run_q;
  logic          data_run_q;
  logic [31:0]   instr_word_q;
  logic [31:0]   data_word_q;
  logic [1:0]    ld_off_q;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] instr_idx;
  logic [AW-1:0] data_idx;
  logic          ld_fire;
  logic          st_fire;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   ld_shifted;
  logic          misalign_now;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;

  // Fetches are word aligned; the byte offset bits carry no information.
  logic          unused_fetch_off;
  assign unused_fetch_off = ^instr_addr_i[1:0];

  assign instr_idx = instr_addr_i[AW+1:2];
  assign data_idx  = data_addr_i[AW+1:2];
  assign ld_fire   = (state_q == LOAD) && ld_valid_i;
  assign st_fire   = (state_q == RUN) && !wen0_i;

  lane_align u_lane_align (
    .st_off   (data_addr_i[1:0]),
    .wmask    (wmask0_i),
    .wdata    (data_i),
    .ld_off   (ld_off_q),
    .rword    (data_word_q),
    .st_mask  (st_mask),
    .st_data  (st_data),
    .ld_data  (ld_shifted),
    .misalign (misalign_now)
  );

  // Single write port: the loader owns it in LOAD, the core's data port in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = data_idx;
    mem_wdata = st_data;
    mem_wmask = st_mask;
    if (ld_fire) begin
      mem_we    = 1'b1;
      mem_waddr = wcnt_q;
      mem_wdata = ld_data_i;
      mem_wmask = MASK_W;
    end else if (st_fire) begin
      mem_we    = 1'b1;
    end
  end

  // Lifecycle FSM and image word counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_fire) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (ld_last_i || (wcnt_q == AW'(DEPTH - 1))) begin
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= LOAD;
      endcase
    end
  end

  // Sticky boundary-crossing flag, watched on every RUN cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misalign_q <= 1'b0;
    end else if ((state_q == RUN) && misalign_now) begin
      misalign_q <= 1'b1;
    end
  end

  // Remember whether the read issued this cycle belongs to the core.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_run_q <= 1'b0;
      data_run_q  <= 1'b0;
    end else begin
      instr_run_q <= (state_q == RUN);
      data_run_q  <= (state_q == RUN);
    end
  end

  // Byte-enabled write port; the array is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) begin
          mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Two registered read ports; non-blocking update gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    instr_word_q <= mem[instr_idx];
    data_word_q  <= mem[data_idx];
    ld_off_q     <= data_addr_i[1:0];
  end

  assign instr_o      = instr_run_q ? instr_word_q : NOP;
  assign data_o       = data_run_q ? ld_shifted : 32'h0;
  assign ld_ready_o   = (state_q == LOAD);
  assign core_rst_n_o = (state_q == RUN);
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_boot_loaded_mem.sv
// Directed bench for boot_loaded_mem: program load, RUN-time stores/loads,
// lane alignment, read-during-write, misalignment and reset behaviour.
module tb_boot_loaded_mem;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [10:0] instr_addr_i;
  logic [31:0] instr_o;
  logic [10:0] data_addr_i;
  logic [31:0] data_i;
  logic        wen0_i;
  logic [3:0]  wmask0_i;
  logic [31:0] data_o;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        core_rst_n_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  boot_loaded_mem dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .instr_addr_i (instr_addr_i),
    .instr_o      (instr_o),
    .data_addr_i  (data_addr_i),
    .data_i       (data_i),
    .wen0_i       (wen0_i),
    .wmask0_i     (wmask0_i),
    .data_o       (data_o),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_last_i    (ld_last_i),
    .ld_ready_o   (ld_ready_o),
    .core_rst_n_o (core_rst_n_o),
    .misalign_o   (misalign_o)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    ld_data_i  = 32'h0;
    wen0_i     = 1'b1;
    wmask0_i   = 4'b0000;
    data_i     = 32'h0;
    data_addr_i  = 11'h0;
    instr_addr_i = 11'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    checks++; if (instr_o !== NOP_W) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_o, NOP_W); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", data_o); end
    checks++; if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ld_ready_o); end
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL reset_core_rst got %b exp 0", core_rst_n_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_o); end
  endtask

  task automatic test_load_program();
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;
    for (int i = 0; i < 4; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = prog[i];
      ld_last_i  = (i == 3);
      checks++; if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL load_ready_beat%0d got %b exp 1", i, ld_ready_o); end
      tick();
    end
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL load_ready_release got %b exp 0", ld_ready_o); end
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL load_core_rst_release got %b exp 0", core_rst_n_o); end
    tick();
    checks++; if (core_rst_n_o !== 1'b1) begin errors++; $display("FAIL load_core_rst_run got %b exp 1", core_rst_n_o); end
    checks++; if (instr_o !== NOP_W) begin errors++; $display("FAIL load_first_run_instr got %h exp %h", instr_o, NOP_W); end
    instr_addr_i = 11'h008;
    tick();
    checks++; if (instr_o !== 32'h0020_81B3) begin errors++; $display("FAIL fetch_addr8 got %h exp 002081b3", instr_o); end
    instr_addr_i = 11'h000;
    tick();
    checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL fetch_addr0 got %h exp 00500093", instr_o); end
  endtask

  task automatic test_store_byte();
    data_addr_i = 11'h040; data_i = 32'hDEAD_BEEF; wmask0_i = 4'b1111; wen0_i = 1'b0;
    tick();
    data_addr_i = 11'h042; data_i = 32'h0000_0011; wmask0_i = 4'b0001; wen0_i = 1'b0;
    tick();
    data_addr_i = 11'h040; wmask0_i = 4'b1111; wen0_i = 1'b1;
    tick();
    checks++; if (data_o !== 32'hDE11_BEEF) begin errors++; $display("FAIL byte_store_word got %h exp de11beef", data_o); end
    data_addr_i = 11'h043; wmask0_i = 4'b0001;
    tick();
    checks++; if (data_o !== 32'h0000_00DE) begin errors++; $display("FAIL byte_load_43 got %h exp 000000de", data_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL byte_misalign got %b exp 0", misalign_o); end
  endtask

  task automatic test_read_during_write();
    data_addr_i = 11'h040; data_i = 32'hCAFE_F00D; wmask0_i = 4'b1111; wen0_i = 1'b0;
    instr_addr_i = 11'h040;
    tick();
    wen0_i = 1'b1;
    checks++; if (data_o !== 32'hDE11_BEEF) begin errors++; $display("FAIL rdw_data_old got %h exp de11beef", data_o); end
    checks++; if (instr_o !== 32'hDE11_BEEF) begin errors++; $display("FAIL rdw_fetch_old got %h exp de11beef", instr_o); end
    tick();
    checks++; if (data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdw_data_new got %h exp cafef00d", data_o); end
    instr_addr_i = 11'h000;
  endtask

  task automatic test_misalign();
    data_addr_i = 11'h044; data_i = 32'h1122_3344; wmask0_i = 4'b1111; wen0_i = 1'b0;
    tick();
    data_addr_i = 11'h048; data_i = 32'h5566_7788;
    tick();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_before got %b exp 0", misalign_o); end
    data_addr_i = 11'h047; data_i = 32'h0000_ABCD; wmask0_i = 4'b0011; wen0_i = 1'b0;
    tick();
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_set got %b exp 1", misalign_o); end
    data_addr_i = 11'h044; wmask0_i = 4'b1111; wen0_i = 1'b1;
    tick();
    checks++; if (data_o !== 32'hCD22_3344) begin errors++; $display("FAIL mis_word44 got %h exp cd223344", data_o); end
    data_addr_i = 11'h048;
    tick();
    checks++; if (data_o !== 32'h5566_7788) begin errors++; $display("FAIL mis_word48 got %h exp 55667788", data_o); end
    wmask0_i = 4'b0000;
    tick();
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", misalign_o); end
  endtask

  task automatic test_full_depth();
    int bad_ready;
    int idx_list [5];
    idx_list = '{0, 1, 2, 255, 511};
    idle_inputs();
    reset_i = 1'b1;
    tick();
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL run_reset_core_rst got %b exp 0", core_rst_n_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL run_reset_misalign got %b exp 0", misalign_o); end
    reset_i = 1'b0;
    bad_ready = 0;
    for (int i = 0; i < 512; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        ld_valid_i = 1'b0;
        ld_data_i  = 32'hFFFF_FFFF;
        tick();
        if (ld_ready_o !== 1'b1) bad_ready++;
      end
      ld_valid_i = 1'b1;
      ld_data_i  = 32'hA500_0000 | 32'(i);
      ld_last_i  = 1'b0;
      if (ld_ready_o !== 1'b1) bad_ready++;
      tick();
    end
    ld_valid_i = 1'b0;
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL full_ready_during_load got %0d exp 0", bad_ready); end
    checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL full_auto_release got %b exp 0", ld_ready_o); end
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL full_release_core_rst got %b exp 0", core_rst_n_o); end
    tick();
    checks++; if (core_rst_n_o !== 1'b1) begin errors++; $display("FAIL full_run_core_rst got %b exp 1", core_rst_n_o); end
    for (int k = 0; k < 5; k++) begin
      data_addr_i  = 11'(idx_list[k] * 4);
      instr_addr_i = 11'(idx_list[k] * 4);
      wmask0_i     = 4'b1111;
      tick();
      checks++; if (data_o !== (32'hA500_0000 | 32'(idx_list[k]))) begin errors++; $display("FAIL full_data_word%0d got %h exp %h", idx_list[k], data_o, 32'hA500_0000 | 32'(idx_list[k])); end
      checks++; if (instr_o !== (32'hA500_0000 | 32'(idx_list[k]))) begin errors++; $display("FAIL full_fetch_word%0d got %h exp %h", idx_list[k], instr_o, 32'hA500_0000 | 32'(idx_list[k])); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h4444_4444;
    exp_w[1] = 32'h5555_5555;
    exp_w[2] = 32'h3333_3333;
    exp_w[3] = 32'hA500_0003;
    idle_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = 32'h1111_1111 * 32'(i + 1);
      tick();
    end
    ld_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL mid_core_rst_after_reset got %b exp 0", core_rst_n_o); end
    checks++; if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready_after_reset got %b exp 1", ld_ready_o); end
    // Core-side store attempts during LOAD must be ignored.
    ld_valid_i = 1'b1; ld_data_i = 32'h4444_4444;
    wen0_i = 1'b0; data_addr_i = 11'h00C; data_i = 32'hBADB_AD00; wmask0_i = 4'b1111;
    tick();
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL mid_data_in_load got %h exp 00000000", data_o); end
    checks++; if (instr_o !== NOP_W) begin errors++; $display("FAIL mid_instr_in_load got %h exp %h", instr_o, NOP_W); end
    ld_data_i = 32'h5555_5555; ld_last_i = 1'b1;
    tick();
    ld_valid_i = 1'b0; ld_last_i = 1'b0; wen0_i = 1'b1;
    checks++; if (core_rst_n_o !== 1'b0) begin errors++; $display("FAIL mid_core_rst_release got %b exp 0", core_rst_n_o); end
    checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready_release got %b exp 0", ld_ready_o); end
    tick();
    checks++; if (core_rst_n_o !== 1'b1) begin errors++; $display("FAIL mid_core_rst_run got %b exp 1", core_rst_n_o); end
    for (int k = 0; k < 4; k++) begin
      data_addr_i = 11'(k * 4);
      tick();
      checks++; if (data_o !== exp_w[k]) begin errors++; $display("FAIL mid_word%0d got %h exp %h", k, data_o, exp_w[k]); end
    end
  endtask

  // Guard against a stuck simulation.
  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // sequence and final report
  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_load_program();
    test_store_byte();
    test_read_during_write();
    test_misalign();
    test_full_depth();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loaded_mem.md
# boot_loaded_mem

Unified instruction/data memory that responds to the core's two memory ports: a read-only fetch port and a byte-masked read/write data port, both with one-cycle registered read latency. After reset it first accepts a program image over a valid/ready load stream. While loading, it holds the core in reset through an active-low core reset output, then releases the core into the run state. It sits beside the core at top level, with its outputs wired to the core's `instr_i`/`data_i` and its inputs driven by the core's address, data, write-enable and mask outputs.

## Interface
- `DEPTH`, 512: number of 32-bit words; byte address width is 11.
- `NOP`, 32'h0000_0013: word returned on the fetch port while not in RUN.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `instr_addr_i`  in  11  fetch byte address; word index is `[10:2]`.
- `instr_o`  out  32  registered fetch word.
- `data_addr_i`  in  11  data byte address.
- `data_i`  in  32  store data from the core, lane-0 aligned.
- `wen0_i`  in  1  store enable, active-low.
- `wmask0_i`  in  4  lane-0 aligned mask: 0001 (byte), 0011 (half) or 1111 (word).
- `data_o`  out  32  registered load data, shifted down to lane 0.
- `ld_valid_i`  in  1  load beat valid.
- `ld_data_i`  in  32  load word.
- `ld_last_i`  in  1  final beat of the image.
- `ld_ready_o`  out  1  load beat accepted when high together with `ld_valid_i`.
- `core_rst_n_o`  out  1  active-low reset to the core.
- `misalign_o`  out  1  sticky flag: a store or load crossed a word boundary.

## Operation
- The FSM has three states: LOAD, RELEASE and RUN. Reset puts it in LOAD.
- **LOAD**
  - `ld_ready_o`=1 and `core_rst_n_o`=0.
  - A word counter `wcnt` starts at 0.
  - On each beat where `ld_valid_i` & `ld_ready_o`: write `mem[wcnt]` = `ld_data_i` and increment `wcnt`.
  - Go to RELEASE on an accepted beat with `ld_last_i`=1, or on the accepted beat where `wcnt`==DEPTH-1.
  - The core ports are ignored: no stores happen, `instr_o`=NOP and `data_o`=0.
- **RELEASE**: one cycle with `ld_ready_o`=0 and `core_rst_n_o` still 0. Next state is RUN.
- **RUN**
  - `core_rst_n_o`=1 and `ld_ready_o`=0.
  - Load-port inputs are ignored.
  - RUN is left only by `reset_i`.
- **Lane alignment in RUN**
  - Offset `off`=`data_addr_i[1:0]`.
  - Effective store mask = (`wmask0_i` << `off`) truncated to 4 bits.
  - Store data = `data_i` << 8·`off`.
  - Lanes shifted beyond lane 3 are dropped; there is no access to the next word.
- **misalign_o** is set when `(wmask0_i << off)` has any bit above bit 3.
  - This is evaluated on every RUN cycle, whether or not a store is enabled, because loads use the same address and mask.
  - It is cleared only by reset.
- **Store**: when `wen0_i`=0, write the masked lanes of `mem[data_addr_i[10:2]]`.
- **Load**: `data_o` = `mem[data_addr_i[10:2]]` >> 8·`off`, using the address registered in the same cycle. Vacated upper bytes are 0. Sign and zero extension belong to the core, not this block.
- **Read-during-write** to the same word on the data port returns the old contents (read-first). The fetch port reading the word being stored also returns the old contents.
- **Reset**
  - Does not clear the memory array.
  - Reset in the middle of LOAD restarts `wcnt` at 0.
  - Reset in RUN returns the block to LOAD and drops `core_rst_n_o` in the next cycle.

## Timing
- Reset values: `instr_o`=NOP, `data_o`=0, `ld_ready_o`=1 (state LOAD), `core_rst_n_o`=0, `misalign_o`=0.
- Fetch and load latency is 1 cycle: an address presented in cycle N gives data valid after edge N+1.
- A store commits at the edge that ends the cycle in which `wen0_i`=0.
- The first RUN-state fetch reflects every loaded word. The earliest core fetch comes 2 cycles after the last accepted beat.
- `misalign_o` rises at the edge after the offending cycle.

## Structure
- The shared package holds:
  - FSM state enum {LOAD, RELEASE, RUN};
  - NOP constant;
  - mask encodings MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111.
- One sub-module, `lane_align`: combinational store shift, load shift and misalign detection. The same logic also serves the future MMIO decoder.
- The array is inferred memory with two read ports and one write port. The write port is muxed between the loader (LOAD) and the core (RUN).

## Test plan
- Reset, then stream 4 beats 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 with `ld_last_i` on beat 4. Required: `ld_ready_o` falls after beat 4, `core_rst_n_o` rises 2 cycles after beat 4, and a fetch of address 8 returns 0x002081B3 next cycle.
- RUN, store word 0xDEADBEEF at address 0x40, then store byte 0x11 (`wmask0_i`=0001) at 0x42. Required: word load at 0x40 returns 0xDE11BEEF and a byte load at 0x43 returns 0x000000DE.
- RUN, store and load the same word in one cycle (old value 0xDE11BEEF, new value 0xCAFEF00D). Required: `data_o` = 0xDE11BEEF, and the next load returns 0xCAFEF00D.
- RUN, halfword store at 0x47 with `data_i`=0x0000ABCD. Required: only byte 0x47 is written, with 0xCD; `misalign_o`=1 and stays 1 until reset.
- Stream DEPTH beats with `ld_last_i`=0 and random `ld_valid_i` gaps. Required: automatic transition to RELEASE after beat 512, and beats with `ld_valid_i`=0 write nothing.
- Assert `reset_i` for 1 cycle mid-load after 3 beats, then reload 2 beats. Required: words 0–1 hold the new values, word 2 keeps its value from the first attempt, and `core_rst_n_o` stays 0 until the new last beat plus 2 cycles.
